// File: rtl/fir_ctrl_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ctrl_sched
//  Brief    : FIR engine sequencer. Owns ap_start/ap_done/ap_idle, the
//             AXI-Stream handshakes, tap/data RAM addressing and the MAC
//             strobes for an external datapath; gates host tap-RAM access.
//  Revision : 1.0  initial release
// ============================================================================
module fir_ctrl_sched #(
    parameter int pADDR_WIDTH = 12,
    parameter int Tape_Num    = 11,
    parameter int pLEN_WIDTH  = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ctrl_start,
    input  logic [pLEN_WIDTH-1:0]  data_length,
    input  logic                   ap_done_clr,
    output logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    input  logic                   cfg_tap_req,
    output logic                   cfg_tap_gnt,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   eng_tap_EN,
    output logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   mac_clr,
    output logic                   mac_en
);

    localparam int              c_PW   = $clog2(Tape_Num);
    localparam logic [c_PW-1:0] c_KMAX = c_PW'(Tape_Num - 1);
    localparam logic [c_PW-1:0] c_NUM  = c_PW'(Tape_Num);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_WAIT_IN = 3'd2,
        S_MAC     = 3'd3,
        S_DRAIN   = 3'd4,
        S_OUT     = 3'd5,
        S_DONE    = 3'd6
    } t_state;

    t_state                r_state;
    t_state                w_next;
    logic [c_PW-1:0]       r_k;
    logic [c_PW-1:0]       r_wr_ptr;
    logic [pLEN_WIDTH-1:0] r_len;
    logic [pLEN_WIDTH-1:0] r_cnt;
    logic                  r_last;
    logic                  r_ap_start;
    logic                  r_ap_done;
    logic                  r_mac_en;
    logic                  r_mac_clr;
    logic                  w_last;
    logic                  w_start_ok;
    logic [c_PW-1:0]       w_idx;

    // Circular-buffer index of the k-th newest sample; the wrap term may
    // overflow c_PW bits transiently but the final result is always < Tape_Num.
    assign w_idx      = (r_wr_ptr >= r_k) ? (r_wr_ptr - r_k) : (r_wr_ptr + c_NUM - r_k);
    assign w_last     = ((r_cnt + pLEN_WIDTH'(1)) == r_len) || r_last;
    assign w_start_ok = ctrl_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign ap_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign ap_start    = r_ap_start;
    assign ap_done     = r_ap_done;
    assign cfg_tap_gnt = cfg_tap_req && ap_idle;
    assign mac_en      = r_mac_en;
    assign mac_clr     = r_mac_clr;

    // State register
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Run bookkeeping: counters, pointers, status bits and delayed MAC strobes
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_k        <= '0;
            r_wr_ptr   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_ap_start <= 1'b0;
            r_ap_done  <= 1'b0;
            r_mac_en   <= 1'b0;
            r_mac_clr  <= 1'b0;
        end else begin
            // RAM reads take one cycle, so the MAC acts on last cycle's read
            r_mac_en  <= (r_state == S_MAC);
            r_mac_clr <= (r_state == S_MAC) && (r_k == '0);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_len      <= (data_length == '0) ? pLEN_WIDTH'(1) : data_length;
                        r_cnt      <= '0;
                        r_k        <= '0;
                        r_ap_start <= 1'b1;
                        r_ap_done  <= 1'b0;
                    end else if (ap_done_clr) begin
                        r_ap_done  <= 1'b0;
                    end
                end
                S_CLEAR: r_k <= (r_k == c_KMAX) ? '0 : r_k + 1'b1;
                S_WAIT_IN: begin
                    if (ss_tvalid) begin
                        r_last     <= ss_tlast;
                        r_ap_start <= 1'b0;
                        r_k        <= '0;
                    end
                end
                S_MAC: r_k <= (r_k == c_KMAX) ? '0 : r_k + 1'b1;
                S_OUT: begin
                    if (sm_tready) begin
                        r_wr_ptr <= (r_wr_ptr == c_KMAX) ? '0 : r_wr_ptr + 1'b1;
                        r_cnt    <= r_cnt + pLEN_WIDTH'(1);
                        if (w_last) r_ap_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and per-state RAM/stream outputs
    always_comb begin
        w_next     = r_state;
        ss_tready  = 1'b0;
        sm_tvalid  = 1'b0;
        sm_tlast   = 1'b0;
        data_EN    = 1'b0;
        data_WE    = 4'h0;
        data_A     = '0;
        eng_tap_EN = 1'b0;
        eng_tap_A  = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = pADDR_WIDTH'({r_k, 2'b00});
                if (r_k == c_KMAX) w_next = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = pADDR_WIDTH'({r_wr_ptr, 2'b00});
                    w_next  = S_MAC;
                end
            end
            S_MAC: begin
                data_EN    = 1'b1;
                data_A     = pADDR_WIDTH'({w_idx, 2'b00});
                eng_tap_EN = 1'b1;
                eng_tap_A  = pADDR_WIDTH'({r_k, 2'b00});
                if (r_k == c_KMAX) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_OUT;
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = w_last;
                if (sm_tready) w_next = w_last ? S_DONE : S_WAIT_IN;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_ctrl_sched
//  Brief    : Self-checking bench for fir_ctrl_sched; table of runs plus a
//             hand-written mid-run reset sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_ctrl_sched;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        ctrl_start, ap_done_clr, cfg_tap_req;
    logic [31:0] data_length;
    logic        ap_start, ap_done, ap_idle, cfg_tap_gnt;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic        sm_tvalid, sm_tready, sm_tlast;
    logic        data_EN, eng_tap_EN, mac_clr, mac_en;
    logic [3:0]  data_WE;
    logic [11:0] data_A, eng_tap_A;

    int checks = 0;
    int errors = 0;
    int wp     = 0;

    fir_ctrl_sched dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .ctrl_start(ctrl_start), .data_length(data_length), .ap_done_clr(ap_done_clr),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .cfg_tap_req(cfg_tap_req), .cfg_tap_gnt(cfg_tap_gnt),
        .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
        .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A),
        .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
        .mac_clr(mac_clr), .mac_en(mac_en)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] len;
        int          tlast_at;   // sample number carrying ss_tlast (0 = never)
        int          stall;      // cycles sm_tready stays low on the first output
        int          exp_outs;   // hand-computed number of outputs in the run
        bit          clr;        // pulse ap_done_clr once in DONE
    } vec_t;

    vec_t vecs[5];
    int   seq3[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge axis_clk);
    endtask

    task automatic do_run(input int r, input vec_t v);
        int macs;
        ctrl_start = 1'b1; data_length = v.len;
        tick();
        ctrl_start = 1'b0;
        check("start_ap_start", ap_start, 1);
        check("start_ap_idle", ap_idle, 0);
        check("start_ap_done", ap_done, 0);
        check("run_gnt", cfg_tap_gnt, 0);
        for (int i = 0; i < 11; i++) begin
            check("clear_WE", data_WE, 4'hF);
            check("clear_A", data_A, 4 * i);
            tick();
        end
        for (int s = 0; s < v.exp_outs; s++) begin
            check("wait_tready", ss_tready, 1);
            check("wait_tvalid_out", sm_tvalid, 0);
            ss_tvalid = 1'b1; ss_tlast = (s + 1 == v.tlast_at);
            #1;
            check("in_WE", data_WE, 4'hF);
            check("in_A", data_A, 4 * wp);
            tick();
            ss_tvalid = 1'b0; ss_tlast = 1'b0;
            check("ap_start_drop", ap_start, 0);
            macs = 0;
            for (int k = 0; k < 11; k++) begin
                if (k == 5) ctrl_start = 1'b1;
                if (k == 6) ctrl_start = 1'b0;
                check("mac_tapEN", eng_tap_EN, 1);
                check("mac_tapA", eng_tap_A, 4 * k);
                check("mac_dataA", data_A, 4 * ((wp - k + 11) % 11));
                if (r == 0 && s == 2) check("seq3_dataA", data_A, seq3[k]);
                check("mac_WE", data_WE, 0);
                check("mac_tready", ss_tready, 0);
                check("mac_clr", mac_clr, (k == 1) ? 1 : 0);
                macs += mac_en;
                tick();
            end
            check("drain_mac_en", mac_en, 1);
            macs += mac_en;
            check("drain_tvalid", sm_tvalid, 0);
            tick();
            macs += mac_en;
            check("mac_en_count", macs, 11);
            for (int c = 0; c < ((s == 0) ? v.stall : 0); c++) begin
                check("hold_tvalid", sm_tvalid, 1);
                check("hold_tlast", sm_tlast, (s + 1 == v.exp_outs) ? 1 : 0);
                check("hold_tready", ss_tready, 0);
                tick();
            end
            check("out_tvalid", sm_tvalid, 1);
            check("out_tlast", sm_tlast, (s + 1 == v.exp_outs) ? 1 : 0);
            sm_tready = 1'b1;
            tick();
            sm_tready = 1'b0;
            wp = (wp + 1) % 11;
        end
        check("done_ap_done", ap_done, 1);
        check("done_ap_idle", ap_idle, 1);
        check("done_tvalid", sm_tvalid, 0);
        check("done_gnt", cfg_tap_gnt, 1);
        if (v.clr) begin
            ap_done_clr = 1'b1;
            tick();
            ap_done_clr = 1'b0;
            check("clr_ap_done", ap_done, 0);
            check("clr_ap_idle", ap_idle, 1);
        end
    endtask

    initial begin
        vecs[0] = '{len: 32'd3, tlast_at: 0, stall: 0, exp_outs: 3, clr: 1'b0};
        vecs[1] = '{len: 32'd4, tlast_at: 0, stall: 5, exp_outs: 4, clr: 1'b1};
        vecs[2] = '{len: 32'd5, tlast_at: 2, stall: 0, exp_outs: 2, clr: 1'b1};
        vecs[3] = '{len: 32'd0, tlast_at: 0, stall: 0, exp_outs: 1, clr: 1'b0};
        vecs[4] = '{len: 32'd2, tlast_at: 1, stall: 3, exp_outs: 1, clr: 1'b1};
        seq3 = '{8, 4, 0, 40, 36, 32, 28, 24, 20, 16, 12};

        axis_rst_n = 1'b0; ctrl_start = 1'b0; ap_done_clr = 1'b0; cfg_tap_req = 1'b0;
        data_length = '0; ss_tvalid = 1'b0; ss_tlast = 1'b0; sm_tready = 1'b0;
        tick(); tick();
        axis_rst_n = 1'b1;
        tick();
        check("rst_ap_idle", ap_idle, 1);
        check("rst_ap_start", ap_start, 0);
        check("rst_ap_done", ap_done, 0);
        check("rst_ss_tready", ss_tready, 0);
        check("rst_sm_tvalid", sm_tvalid, 0);
        check("rst_gnt_noreq", cfg_tap_gnt, 0);
        check("rst_mac_en", mac_en, 0);
        cfg_tap_req = 1'b1;
        #1;
        check("rst_gnt_req", cfg_tap_gnt, 1);

        for (int r = 0; r < 5; r++) do_run(r, vecs[r]);

        // Reset while the second sample is being accumulated
        ss_tvalid = 1'b1; sm_tready = 1'b1;
        ctrl_start = 1'b1; data_length = 32'd4;
        tick();
        ctrl_start = 1'b0;
        for (int i = 0; i < 29; i++) tick();
        check("pre_rst_in_mac", eng_tap_EN, 1);
        check("pre_rst_ap_idle", ap_idle, 0);
        #2;
        axis_rst_n = 1'b0;
        #1;
        check("mid_rst_ap_idle", ap_idle, 1);
        check("mid_rst_ap_start", ap_start, 0);
        check("mid_rst_tapEN", eng_tap_EN, 0);
        check("mid_rst_dataEN", data_EN, 0);
        check("mid_rst_tready", ss_tready, 0);
        check("mid_rst_tvalid", sm_tvalid, 0);
        check("mid_rst_mac_en", mac_en, 0);
        ss_tvalid = 1'b0; sm_tready = 1'b0;
        tick();
        axis_rst_n = 1'b1;
        tick();
        ctrl_start = 1'b1; data_length = 32'd1;
        tick();
        ctrl_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check("reclear_WE", data_WE, 4'hF);
            check("reclear_A", data_A, 4 * i);
            tick();
        end
        check("reclear_wait", ss_tready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
